// File: rtl/bmem_row_writer_pkg.sv
// Shared types and default geometry for the row-buffer write front end.
package bmem_wr_pkg;

  localparam int DEF_PIX_W  = 8;
  localparam int DEF_COLS   = 640;
  localparam int DEF_ROWS   = 480;
  localparam int DEF_ADDR_W = $clog2(DEF_ROWS);
  localparam int DEF_ROW_W  = DEF_PIX_W * DEF_COLS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  function automatic int row_width(input int pix_w, input int cols);
    return pix_w * cols;
  endfunction

endpackage

// File: rtl/bmem_row_writer_if.sv
// Raster pixel stream: the source drives pixels, the row writer answers with ready.
interface bmem_row_writer_if
  import bmem_wr_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W
);

  // A pixel moves on a rising edge where pix_valid && pix_ready. The source
  // holds pix_data/pix_sof stable while pix_valid is high and not accepted;
  // pix_ready never looks at pix_valid.
  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pix_data;
  logic             pix_sof;

  modport master (
    output pix_valid,
    output pix_data,
    output pix_sof,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  pix_sof,
    output pix_ready
  );

endinterface

// File: rtl/bmem_row_writer.sv
// Packs a raster pixel stream into one word per row and writes it through
// buffer port 1, lending that port to the downstream reader between writes.
module bmem_row_writer
  import bmem_wr_pkg::*;
#(
  parameter int PIX_W  = DEF_PIX_W,
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = $clog2(ROWS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bmem_row_writer_if.slave        pix,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr1,
  output logic [PIX_W*COLS-1:0]   mem_din,
  input  logic [ADDR_W-1:0]       rd1_addr,
  output logic                    rd1_gnt,
  output logic                    row_done,
  output logic [ADDR_W-1:0]       row_idx,
  output logic                    frame_done,
  output logic                    sof_err,
  output state_t                  dbg_state
);

  localparam int ROW_W = row_width(PIX_W, COLS);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);

  state_t            state_q;
  logic [COL_W-1:0]  col_q;
  logic [ADDR_W-1:0] row_q;
  logic [ROW_W-1:0]  row_buf_q;
  logic              sof_err_q;

  logic in_write;
  logic accept;

  assign in_write = (state_q == S_WRITE);
  assign accept   = pix.pix_valid && pix.pix_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      row_buf_q <= '0;
      sof_err_q <= 1'b0;
    end else begin
      sof_err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          // Anything before a start-of-frame is dropped on the floor.
          if (accept && pix.pix_sof) begin
            row_buf_q[PIX_W-1:0] <= pix.pix_data;
            col_q   <= COL_W'(1);
            row_q   <= '0;
            state_q <= S_FILL;
          end
        end
        S_FILL: begin
          if (accept) begin
            if (pix.pix_sof) begin
              // Restart: the partial row is abandoned, not flushed.
              row_buf_q[PIX_W-1:0] <= pix.pix_data;
              col_q     <= COL_W'(1);
              row_q     <= '0;
              sof_err_q <= 1'b1;
            end else begin
              row_buf_q[int'(col_q)*PIX_W +: PIX_W] <= pix.pix_data;
              if (col_q == COL_LAST) begin
                col_q   <= '0;
                state_q <= S_WRITE;
              end else begin
                col_q <= col_q + 1'b1;
              end
            end
          end
        end
        S_WRITE: begin
          if (row_q == ROW_LAST) begin
            row_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            row_q   <= row_q + 1'b1;
            state_q <= S_FILL;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Port 1 belongs to the reader except during the single write cycle.
  assign pix.pix_ready = !in_write;
  assign mem_we        = in_write;
  assign rd1_gnt       = !in_write;
  assign mem_addr1     = in_write ? row_q : rd1_addr;
  assign mem_din       = row_buf_q;
  assign row_done      = in_write;
  assign frame_done    = in_write && (row_q == ROW_LAST);
  assign sof_err       = sof_err_q;
  assign row_idx       = row_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/bmem_row_writer.md
# bmem_row_writer

Write-side front end for the 480-row × 5120-bit dual-port row buffer. It accepts a raster pixel stream (8-bit, 640 pixels per row, 480 rows per frame) over a valid/ready handshake and packs each row into one 5120-bit word. It writes the word into the buffer through port 1 (we/addr1/din). It also arbitrates port-1 addressing between its own row writes and a downstream reader, which keeps port 2 exclusively.

## Interface
- PIX_W, 8, pixel width in bits
- COLS, 640, pixels per row
- ROWS, 480, rows per frame
- ADDR_W, 9, row address width, ceil(log2(ROWS))
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  reset; asynchronous, active-low
- pix_valid  in  1  pixel present
- pix_ready  out  1  block accepts pixel this cycle
- pix_data  in  PIX_W  pixel value
- pix_sof  in  1  marks first pixel of a frame (row 0, col 0)
- mem_we  out  1  buffer write enable
- mem_addr1  out  ADDR_W  buffer port-1 address (write or granted read)
- mem_din  out  PIX_W*COLS  buffer write data
- rd1_addr  in  ADDR_W  downstream reader's requested port-1 row
- rd1_gnt  out  1  port 1 serves rd1_addr this cycle
- row_done  out  1  one-cycle pulse; row written this cycle
- row_idx  out  ADDR_W  row being filled or written
- frame_done  out  1  one-cycle pulse; last row written this cycle
- sof_err  out  1  one-cycle pulse; mid-frame SOF caused a restart

## Operation
- Accept occurs when pix_valid && pix_ready.
- States: S_IDLE, S_FILL, S_WRITE.
- S_IDLE: pix_ready=1. Pixels without pix_sof are accepted and discarded. An accepted pixel with pix_sof goes into col 0 and sets col=1, row=0, then the block moves to S_FILL.
- S_FILL: pix_ready=1. Each accepted pixel is stored at row_buf[col*PIX_W +: PIX_W], and col increments. If the pixel is accepted at col==COLS-1, the block moves to S_WRITE with col=0.
- S_FILL, accepted pixel with pix_sof: the frame restarts. The partial row is discarded, the pixel goes into col 0, col=1, row=0, and sof_err pulses in the next cycle. The block stays in S_FILL.
- S_WRITE (exactly one cycle): pix_ready=0, mem_we=1, mem_addr1=row, mem_din=row_buf, row_done=1, rd1_gnt=0.
  - If row==ROWS-1: frame_done=1, row resets to 0, next state is S_IDLE.
  - Otherwise: row increments and the next state is S_FILL.
- Packing: column c occupies bits [c*PIX_W +: PIX_W], so col 0 sits at the LSBs.
- Port-1 arbitration:
  - Outside S_WRITE: mem_addr1=rd1_addr and rd1_gnt=1.
  - In S_WRITE: mem_addr1 is the write row and rd1_gnt=0. The reader must ignore the dout1 produced from that cycle and re-present its address.
- row_idx always equals the internal row counter.
- Counters: col is ceil(log2(COLS)) bits and row is ADDR_W bits. Neither may exceed COLS-1 or ROWS-1; wrap is explicit, never by overflow.

## Timing
- Reset values:
  - state=S_IDLE, col=0, row=0, row_buf=0.
  - Derived outputs: pix_ready=1, mem_we=0, mem_din=0, mem_addr1=rd1_addr, rd1_gnt=1, row_done=0, frame_done=0, sof_err=0, row_idx=0.
- pix_ready, mem_we, rd1_gnt and mem_addr1 are combinational decodes of the registered state. They do not depend on pix_valid.
- Row write happens 1 cycle after the last pixel's accept.
- Full-rate throughput is COLS+1 cycles per row. pix_ready drops for exactly 1 cycle per row.
- A read granted in cycle t returns buffer dout1 at t+1, which is the buffer's own latency.
- Reset asserted mid-row or mid-write: all state clears immediately. A write cycle cut by reset does not complete. The partial frame is lost, and the next frame needs SOF.
- pix_valid without SOF after frame_done is dropped in S_IDLE.

## Structure
- Shared package bmem_wr_pkg holds:
  - the state enum (S_IDLE/S_FILL/S_WRITE)
  - defaults PIX_W, COLS, ROWS
  - ADDR_W derivation
  - row width localparam PIX_W*COLS
- Single module; no sub-module. The port-1 mux is inline. The buffer itself is instantiated by the parent, not here.

## Test plan
- Single frame, pix_valid held 1, pixel = (col+row)[7:0], SOF on the first pixel -> 480 writes. Each write has mem_addr1=row and mem_din byte c = (c+row)[7:0]. row_done fires 480 times and frame_done fires once, on row 479.
- Pre-SOF garbage: 5 pixels without SOF, then a frame -> the garbage is never written; row 0 col 0 holds the SOF pixel.
- Mid-frame SOF at row 3, col 100 -> sof_err pulses once. The next write targets addr 0 with the restarted row. Rows 0–2 are not rewritten until the new frame reaches them.
- Reader hammer: rd1_addr=17 held through a frame -> rd1_gnt=0 exactly in each write cycle and 1 otherwise. mem_addr1 equals 17 in every granted cycle.
- Random pix_valid gaps (50%) -> written data is identical to the back-to-back run. pix_ready=0 only in write cycles.
- Reset pulse during the write cycle of row 10 -> mem_we=0 after reset, row_idx=0, state is S_IDLE, and the next frame's first write goes to addr 0.
